// File: rtl/ram_sp_pkg.sv
// Shared types and helpers for the ram_sp_ctrl scratch memory.
// Holds the FSM state encoding, the latency limit and the parity function.
package ram_sp_pkg;

    typedef enum logic [0:0] {CLEAR, READY} ram_sp_state_e;

    localparam int RD_LAT_MAX = 2;

    // Widest data word supported by calc_parity; narrower words are zero-extended.
    localparam int DATA_W_MAX = 64;

    function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage array with one write port and one registered read port for ram_sp_ctrl.
// With RAM_SP_PARITY_EN defined, a parity column is stored and checked on every read.
module ram_sp_array
    import ram_sp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rzero_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rpar_err_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage itself has no reset; the clear sequencer zeroes it word by word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only loads on a read, so the output holds between reads.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef RAM_SP_PARITY_EN
    logic mem_par [DEPTH];
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_par[waddr_i] <= calc_parity(DATA_W_MAX'(wdata_i));
        end
    end

    // Out-of-range reads are forced to zero and never report a parity error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else if (re_i) begin
            par_err_q <= !rzero_i &&
                         (calc_parity(DATA_W_MAX'(mem[raddr_i])) != mem_par[raddr_i]);
        end
    end

    assign rpar_err_o = par_err_q;
`else
    assign rpar_err_o = 1'b0;
`endif

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port scratch RAM controller: clear-on-reset sequencer, range check and read pipeline.
// Optional per-word parity is enabled with RAM_SP_PARITY_EN.
module ram_sp_ctrl
    import ram_sp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ce_mem,
    input  logic              we_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] datai_mem,
    output logic              rdy_mem,
    output logic [DATA_W-1:0] datao_mem,
    output logic              rd_vld_mem,
    output logic              addr_err_mem,
    output logic              par_err_mem
);

    // DEPTH may equal 2**ADDR_W, so the range check uses one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    ram_sp_state_e     state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    logic              in_range;
    logic              req_acc;
    logic              rd_req;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;
    logic              arr_rzero;
    logic [ADDR_W-1:0] arr_raddr;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_perr;

    logic              rd_vld_q;
    logic              addr_err_q;

    assign in_range = ({1'b0, addr_mem} < DEPTH_EXT);
    assign req_acc  = (state_q == READY) && ce_mem;
    assign rd_req   = req_acc && !we_mem;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            if (clr_ptr_q == LAST_IDX) begin
                state_d   = READY;
                clr_ptr_d = '0;
            end else begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // The clear sequencer owns the write port until READY; writes are blocked while in reset.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = addr_mem;
        arr_wdata = datai_mem;
        if (state_q == CLEAR) begin
            arr_we    = rstn;
            arr_waddr = clr_ptr_q;
            arr_wdata = '0;
        end else if (req_acc && we_mem && in_range) begin
            arr_we    = rstn;
        end
    end

    generate
        if (RD_LAT >= RD_LAT_MAX) begin : g_addr_stage
            logic              stg_vld_q;
            logic              stg_oor_q;
            logic [ADDR_W-1:0] stg_addr_q;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    stg_vld_q  <= 1'b0;
                    stg_oor_q  <= 1'b0;
                    stg_addr_q <= '0;
                end else begin
                    stg_vld_q <= rd_req;
                    if (rd_req) begin
                        stg_oor_q  <= !in_range;
                        stg_addr_q <= addr_mem;
                    end
                end
            end

            assign arr_re    = stg_vld_q;
            assign arr_rzero = stg_oor_q;
            assign arr_raddr = stg_addr_q;
        end else begin : g_no_stage
            assign arr_re    = rd_req;
            assign arr_rzero = !in_range;
            assign arr_raddr = addr_mem;
        end
    endgenerate

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .rstn       (rstn),
        .we_i       (arr_we),
        .waddr_i    (arr_waddr),
        .wdata_i    (arr_wdata),
        .re_i       (arr_re),
        .rzero_i    (arr_rzero),
        .raddr_i    (arr_raddr),
        .rdata_o    (arr_rdata),
        .rpar_err_o (arr_perr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_vld_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_vld_q   <= arr_re;
            addr_err_q <= req_acc && !in_range;
        end
    end

    assign rdy_mem      = (state_q == READY);
    assign datao_mem    = arr_rdata;
    assign rd_vld_mem   = rd_vld_q;
    assign addr_err_mem = addr_err_q;
    assign par_err_mem  = rd_vld_q && arr_perr;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: instance A uses defaults (DEPTH=16, RD_LAT=1),
// instance B uses DEPTH=12, RD_LAT=2. Parity checks depend on RAM_SP_PARITY_EN.
module tb_ram_sp_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ce   [2];
    logic       we   [2];
    logic [3:0] addr [2];
    logic [7:0] din  [2];
    logic       rdy  [2];
    logic [7:0] dout [2];
    logic       rvld [2];
    logic       aerr [2];
    logic       perr [2];

    int         n_checks = 0;
    int         n_pass   = 0;
    bit         perr_seen = 1'b0;
    int         depth_of [2] = '{16, 12};
    logic [7:0] exp_mem  [2][16];

    typedef struct {
        int         d;
        bit         wr;
        logic [3:0] a;
        logic [7:0] data;
        logic [7:0] exp_dout;
        bit         exp_err;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    ram_sp_ctrl u_dut_a (
        .clk          (clk),
        .rstn         (rstn),
        .ce_mem       (ce[0]),
        .we_mem       (we[0]),
        .addr_mem     (addr[0]),
        .datai_mem    (din[0]),
        .rdy_mem      (rdy[0]),
        .datao_mem    (dout[0]),
        .rd_vld_mem   (rvld[0]),
        .addr_err_mem (aerr[0]),
        .par_err_mem  (perr[0])
    );

    ram_sp_ctrl #(
        .DATA_W (8),
        .ADDR_W (4),
        .DEPTH  (12),
        .RD_LAT (2)
    ) u_dut_b (
        .clk          (clk),
        .rstn         (rstn),
        .ce_mem       (ce[1]),
        .we_mem       (we[1]),
        .addr_mem     (addr[1]),
        .datai_mem    (din[1]),
        .rdy_mem      (rdy[1]),
        .datao_mem    (dout[1]),
        .rd_vld_mem   (rvld[1]),
        .addr_err_mem (aerr[1]),
        .par_err_mem  (perr[1])
    );

    always @(negedge clk) begin
        if (perr[0] === 1'b1 || perr[1] === 1'b1) perr_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] data,
                            input bit exp_err, input string tag);
        ce[d] = 1'b1; we[d] = 1'b1; addr[d] = a; din[d] = data;
        tick();
        ce[d] = 1'b0; we[d] = 1'b0;
        check({tag, "_aerr"}, 32'(aerr[d]), 32'(exp_err));
        check({tag, "_novld"}, 32'(rvld[d]), 32'h0);
        if (int'(a) < depth_of[d]) exp_mem[d][a] = data;
    endtask

    task automatic do_read(input int d, input logic [3:0] a, input logic [7:0] exp_d,
                           input bit exp_err, input bit exp_perr, input string tag);
        ce[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
        tick();
        ce[d] = 1'b0;
        check({tag, "_aerr"}, 32'(aerr[d]), 32'(exp_err));
        if (d == 1) begin
            check({tag, "_vld_early"}, 32'(rvld[d]), 32'h0);
            tick();
        end
        check({tag, "_vld"}, 32'(rvld[d]), 32'h1);
        check({tag, "_data"}, 32'(dout[d]), 32'(exp_d));
        check({tag, "_perr"}, 32'(perr[d]), 32'(exp_perr));
        tick();
        check({tag, "_vld_end"}, 32'(rvld[d]), 32'h0);
        check({tag, "_data_hold"}, 32'(dout[d]), 32'(exp_d));
    endtask

    // Releases reset with write requests pending and measures how long rdy stays low.
    task automatic release_and_clear(input string tag);
        int seen_at [2];
        bit strobe;
        seen_at = '{0, 0};
        strobe  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 4'd0; din[d] = 8'hFF;
        end
        rstn = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (seen_at[d] == 0) begin
                    strobe = strobe | rvld[d] | aerr[d];
                    if (rdy[d]) begin
                        seen_at[d] = cyc;
                        ce[d] = 1'b0; we[d] = 1'b0;
                    end
                end
            end
            if (seen_at[0] != 0 && seen_at[1] != 0) break;
        end
        check({tag, "_clear_len_a"}, 32'(seen_at[0]), 32'd16);
        check({tag, "_clear_len_b"}, 32'(seen_at[1]), 32'd12);
        check({tag, "_clear_nostrobe"}, 32'(strobe), 32'h0);
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b0; we[d] = 1'b0;
            for (int i = 0; i < 16; i++) exp_mem[d][i] = 8'h00;
        end
    endtask

    initial begin
        int got [2];
        int first [2];
        int last [2];
        int lim;

        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b1; we[d] = 1'b1; addr[d] = 4'd0; din[d] = 8'hFF;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_rdy%0d", d),    32'(rdy[d]),  32'h0);
            check($sformatf("rst_dout%0d", d),   32'(dout[d]), 32'h0);
            check($sformatf("rst_vld%0d", d),    32'(rvld[d]), 32'h0);
            check($sformatf("rst_aerr%0d", d),   32'(aerr[d]), 32'h0);
            check($sformatf("rst_perr%0d", d),   32'(perr[d]), 32'h0);
        end

        release_and_clear("init");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < depth_of[d]; i++) begin
                do_read(d, 4'(i), 8'h00, 1'b0, 1'b0, $sformatf("clr%0d_a%0d", d, i));
            end
        end

        vecs[0]  = '{0, 1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{0, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1, 1'b1, 4'd3,  8'hA5, 8'h00, 1'b0};
        vecs[3]  = '{1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
        vecs[4]  = '{1, 1'b1, 4'd13, 8'h77, 8'h00, 1'b1};
        vecs[5]  = '{1, 1'b0, 4'd13, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{1, 1'b0, 4'd12, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1, 1'b0, 4'd11, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{0, 1'b0, 4'd15, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{0, 1'b1, 4'd15, 8'h5A, 8'h00, 1'b0};
        vecs[10] = '{0, 1'b0, 4'd15, 8'h00, 8'h5A, 1'b0};
        vecs[11] = '{1, 1'b1, 4'd0,  8'h11, 8'h00, 1'b0};
        vecs[12] = '{1, 1'b0, 4'd0,  8'h00, 8'h11, 1'b0};
        vecs[13] = '{0, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].d, vecs[i].a, vecs[i].data, vecs[i].exp_err,
                         $sformatf("vec%0d", i));
            end else begin
                do_read(vecs[i].d, vecs[i].a, vecs[i].exp_dout, vecs[i].exp_err, 1'b0,
                        $sformatf("vec%0d", i));
            end
        end

        // The dropped out-of-range write must leave every word of B as tracked.
        for (int i = 0; i < 12; i++) begin
            do_read(1, 4'(i), exp_mem[1][i], 1'b0, 1'b0, $sformatf("oor_keep_a%0d", i));
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < depth_of[d]; i++) begin
                do_write(d, 4'(i), 8'(i + 16), 1'b0, $sformatf("fill%0d_a%0d", d, i));
            end
        end

        got   = '{0, 0};
        first = '{0, 0};
        last  = '{0, 0};
        for (int cyc = 0; cyc < 24; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                ce[d] = (cyc < depth_of[d]);
                we[d] = 1'b0;
                addr[d] = 4'(cyc);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                if (rvld[d]) begin
                    check($sformatf("stream%0d_%0d", d, got[d]), 32'(dout[d]), 32'(got[d] + 16));
                    if (got[d] == 0) first[d] = cyc;
                    last[d] = cyc;
                    got[d]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            ce[d] = 1'b0;
            check($sformatf("stream%0d_count", d), 32'(got[d]), 32'(depth_of[d]));
            check($sformatf("stream%0d_contig", d), 32'(last[d] - first[d] + 1), 32'(depth_of[d]));
        end
        check("stream_lat_a", 32'(first[0]), 32'd0);
        check("stream_lat_b", 32'(first[1]), 32'd1);

        // Read on B is in the address stage when reset hits; it must never complete.
        ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd3;
        tick();
        ce[1] = 1'b0;
        check("midrst_vld_pre", 32'(rvld[1]), 32'h0);
        rstn = 1'b0;
        lim = 3;
        for (int k = 0; k < lim; k++) begin
            tick();
            check($sformatf("midrst_vld_%0d", k), 32'(rvld[1]), 32'h0);
            check($sformatf("midrst_rdy_%0d", k), 32'(rdy[1]), 32'h0);
            check($sformatf("midrst_dout_%0d", k), 32'(dout[1]), 32'h0);
        end
        release_and_clear("midrst");
        do_read(0, 4'd3, 8'h00, 1'b0, 1'b0, "midrst_lost_a");
        do_read(1, 4'd3, 8'h00, 1'b0, 1'b0, "midrst_lost_b");

`ifdef RAM_SP_PARITY_EN
        do_write(0, 4'd5, 8'h3C, 1'b0, "par_wr");
        do_read(0, 4'd5, 8'h3C, 1'b0, 1'b0, "par_good");
        u_dut_a.u_array.mem[5][0] = ~u_dut_a.u_array.mem[5][0];
        do_read(0, 4'd5, 8'h3D, 1'b0, 1'b1, "par_bad");
        do_read(1, 4'd13, 8'h00, 1'b1, 1'b0, "par_oor");
`else
        tick();
        check("par_never", 32'(perr_seen), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_ctrl.md
Name: ram_sp_ctrl

Overview:
- Parametrised single-port synchronous RAM with a self-clearing init sequencer, a configurable registered read pipeline, a ready indication and read-valid strobe.
- Next-generation local scratch memory for testbench-facing datapaths.
- Generalises width, depth and read latency.
- Adds out-of-range address detection and optional per-word parity.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 4, address width in bits (>=1).
- DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from accepted read to data; legal values 1 or 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- ce_mem  input  1  chip enable; a request is present when high.
- we_mem  input  1  1 = write, 0 = read; qualified by ce_mem.
- addr_mem  input  ADDR_W  word address.
- datai_mem  input  DATA_W  write data.
- rdy_mem  output  1  high when requests are accepted (state READY).
- datao_mem  output  DATA_W  read data; holds last value between reads.
- rd_vld_mem  output  1  one-cycle strobe, datao_mem valid this cycle.
- addr_err_mem  output  1  one-cycle strobe on an accepted request with addr_mem >= DEPTH.
- par_err_mem  output  1  parity error strobe, aligned with rd_vld_mem (see Optional Feature).

Behaviour:
- Reset is synchronous: sampled only at the posedge of clk with rstn low. No asynchronous path.
- Reset values: rdy_mem=0, datao_mem=0, rd_vld_mem=0, addr_err_mem=0, par_err_mem=0, read pipeline flushed, clr_ptr=0, state=CLEAR.
- Memory contents are not reset directly; the CLEAR state zeroes them.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 (and parity 0) to mem[clr_ptr], then clr_ptr++.
  - When clr_ptr==DEPTH-1 is written, the next state is READY.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - rdy_mem=0; ce_mem is ignored, with no write, read or error strobes.
- READY (rdy_mem=1); request accepted when ce_mem=1:
  - Write (we_mem=1, addr<DEPTH): mem[addr] <= datai_mem at this edge. No output change.
  - Read (we_mem=0, addr<DEPTH):
    - RD_LAT=1: datao_mem is updated and rd_vld_mem=1 in the cycle after the accepting edge.
    - RD_LAT=2: one cycle later, through a registered address/data stage.
  - Reads are fully pipelined: back-to-back reads every cycle produce back-to-back rd_vld_mem in the same order.
  - Read after write to the same address in the next cycle returns the new data.
  - Out-of-range (addr>=DEPTH):
    - Write is dropped with no memory change.
    - Read produces rd_vld_mem with datao_mem=0.
    - addr_err_mem pulses in the cycle after acceptance for both cases.
  - ce_mem=0: no operation.
- Width rules:
  - addr_mem is compared in full ADDR_W against DEPTH.
  - Memory index uses the addr_mem bits directly; no truncation aliasing.
- Reset mid-operation:
  - In-flight reads are discarded with no rd_vld_mem.
  - The FSM returns to CLEAR and the full clear re-runs.
  - Prior contents are lost (zeroed).
- rstn held low: outputs stay at reset values and clr_ptr stays 0.

Optional Feature:
- Macro: RAM_SP_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit (^datai_mem) on write.
  - On read, recomputed parity is compared with the stored bit.
  - par_err_mem pulses with rd_vld_mem on mismatch.
  - Out-of-range reads never flag parity.
- Undefined:
  - No parity storage.
  - par_err_mem is tied to 0; the port stays for interface stability.

Decomposition:
- Package ram_sp_pkg holds:
  - typedef enum logic [0:0] {CLEAR, READY} ram_sp_state_e;
  - localparam RD_LAT_MAX = 2;
  - function calc_parity.
- One natural sub-module, ram_sp_array: the storage array with a registered read port and optional parity column.
- The top-level module holds the FSM, the clear pointer, the range check and the latency pipeline.

Test Plan:
- Clear sequence:
  - Stimulus: release rstn; hold ce_mem=1, we_mem=1, datai_mem=8'hFF.
  - Response: rdy_mem=0 for exactly 16 cycles, then 1.
  - Afterwards, reading addresses 0..15 returns 8'h00 each, with no write having taken effect.
- Write/read latency:
  - Stimulus: write 8'hA5 to address 3, then read address 3 on the next cycle.
  - RD_LAT=1: datao_mem=8'hA5 with rd_vld_mem=1 one cycle after the read edge.
  - RD_LAT=2: two cycles after the read edge.
- Streaming reads:
  - Stimulus: write address i = i+8'h10 for i=0..15, then 16 back-to-back reads.
  - Response: 16 consecutive rd_vld_mem pulses, data 8'h10..8'h1F in order.
- Out-of-range:
  - Setup: DEPTH=12.
  - Stimulus: write 8'h77 to address 13, then read address 13.
  - Response: addr_err_mem pulses after each request; read returns 0 with rd_vld_mem=1.
  - Addresses 0..11 are unchanged.
- Reset mid-read:
  - Stimulus (RD_LAT=2): read issued, then rstn=0 on the next edge.
  - Response: no rd_vld_mem; rdy_mem=0 for DEPTH cycles after release.
  - Previously written data now reads 0.
- Parity (RAM_SP_PARITY_EN):
  - Stimulus: write 8'h3C to address 5; force-flip the stored bit 0; read address 5.
  - Response: par_err_mem=1 with rd_vld_mem.
  - Without the macro, par_err_mem stays 0 throughout.
